// File: rtl/scratch_pkg.sv
// +------------------------------------------------------------------+
// | scratch_pkg: shared geometry and defaults for the scratchpad     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package scratch_pkg;

    localparam int SCRATCH_ADDR_WIDTH   = 13;
    localparam int SCRATCH_DATA_WIDTH   = 64;
    localparam int SCRATCH_DEPTH        = 8192;
    localparam int SCRATCH_FIFO_DEPTH   = 8;
    localparam int SCRATCH_STALL_MARGIN = 3;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scratch_rsp_fifo.sv
// +------------------------------------------------------------------+
// | scratch_rsp_fifo: show-ahead synchronous FIFO with count output  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module scratch_rsp_fifo
    import scratch_pkg::*;
#(
    parameter int WIDTH = SCRATCH_DATA_WIDTH,
    parameter int DEPTH = SCRATCH_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             do_rd;
    logic             do_wr;

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign full     = (cnt == CNT_W'(DEPTH));
    assign do_rd    = rd_en && (cnt != '0);
    assign do_wr    = wr_en && (!full || do_rd);
    assign overflow = wr_en && full && !do_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = (cnt != '0) ? mem[rd_ptr] : '0;
    assign count   = cnt;

endmodule

`default_nettype wire

// File: rtl/sparse_scratchpad_responder.sv
// +------------------------------------------------------------------+
// | sparse_scratchpad_responder: scratchpad RAM + ordered load skid  |
// | Optional: SCRATCH_OVERFLOW_CHECK_EN adds sticky err_overflow.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sparse_scratchpad_responder
    import scratch_pkg::*;
#(
    parameter int ADDR_WIDTH   = SCRATCH_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SCRATCH_DATA_WIDTH,
    parameter int FIFO_DEPTH   = SCRATCH_FIFO_DEPTH,
    parameter int STALL_MARGIN = SCRATCH_STALL_MARGIN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_scratch_ld,
    input  logic                  req_scratch_st,
    input  logic [ADDR_WIDTH-1:0] req_scratch_addr,
    input  logic [DATA_WIDTH-1:0] req_scratch_d,
    output logic                  req_scratch_stall,
    output logic                  rsp_scratch_push,
    output logic [DATA_WIDTH-1:0] rsp_scratch_q,
`ifdef SCRATCH_OVERFLOW_CHECK_EN
    output logic                  err_overflow,
`endif
    input  logic                  rsp_scratch_stall
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_LEVEL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   STALL_LEVEL = (CNT_W+1)'(FIFO_DEPTH - STALL_MARGIN);

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [CNT_W:0]        occ_next;
    logic                  pop;
    logic                  wr_ok;
    logic                  overflow;

    // Read and write in one block: a same-cycle ld/st to one address returns old data.
    always_ff @(posedge clk) begin
        if (req_scratch_st) ram[req_scratch_addr] <= req_scratch_d;
        if (req_scratch_ld) rd_data <= ram[req_scratch_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_valid <= 1'b0;
        else        rd_valid <= req_scratch_ld;
    end

    scratch_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (rd_valid),
        .wr_data  (rd_data),
        .rd_en    (pop),
        .rd_data  (rsp_scratch_q),
        .count    (count),
        .overflow (overflow)
    );

    assign pop              = (count != '0) && !rsp_scratch_stall;
    assign rsp_scratch_push = pop;

    assign wr_ok      = rd_valid && ((count != FULL_LEVEL) || pop);
    assign count_next = count + CNT_W'(wr_ok) - CNT_W'(pop);
    assign occ_next   = {1'b0, count_next} + (CNT_W+1)'(req_scratch_ld);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_scratch_stall <= 1'b0;
        else        req_scratch_stall <= (occ_next >= STALL_LEVEL);
    end

`ifdef SCRATCH_OVERFLOW_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        err_overflow <= 1'b0;
        else if (overflow) err_overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!overflow) else $error("scratchpad response FIFO overflow, load data dropped");
        end
    end
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sparse_scratchpad_responder.sv
// +------------------------------------------------------------------+
// | tb_sparse_scratchpad_responder: randomized check vs. queue model |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sparse_scratchpad_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld = 1'b0;
    logic        st = 1'b0;
    logic [12:0] addr = '0;
    logic [63:0] d = '0;
    logic        rs = 1'b0;
    logic        req_stall;
    logic        push;
    logic [63:0] q;
`ifdef SCRATCH_OVERFLOW_CHECK_EN
    logic        err_overflow;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: memory array, one-deep in-flight slot, ordered response queue.
    logic [63:0] mem_m [8192];
    logic [63:0] q_m [$];
    bit          infl_v = 0;
    logic [63:0] infl_d = '0;
    bit          stall_m = 0;

    sparse_scratchpad_responder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_scratch_ld    (ld),
        .req_scratch_st    (st),
        .req_scratch_addr  (addr),
        .req_scratch_d     (d),
        .req_scratch_stall (req_stall),
        .rsp_scratch_push  (push),
        .rsp_scratch_q     (q),
`ifdef SCRATCH_OVERFLOW_CHECK_EN
        .err_overflow      (err_overflow),
`endif
        .rsp_scratch_stall (rs)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] expected();
        logic       p;
        logic [63:0] h;
        p = (q_m.size() != 0) && !rs;
        h = (q_m.size() != 0) ? q_m[0] : 64'd0;
        return {p, h, stall_m};
    endfunction

    task automatic drive(input logic l, input logic s, input logic [12:0] a,
                         input logic [63:0] dd, input logic r);
        @(negedge clk);
        ld = l; st = s; addr = a; d = dd; rs = r;
        #1;
    endtask

    task automatic advance();
        bit popped;
        popped = (q_m.size() != 0) && !rs;
        @(posedge clk);
        if (popped) void'(q_m.pop_front());
        if (infl_v && q_m.size() < DEPTH) q_m.push_back(infl_d);
        infl_v = ld;
        infl_d = mem_m[addr];
        if (st) mem_m[addr] = d;
        stall_m = (q_m.size() + int'(infl_v)) >= (DEPTH - MARGIN);
    endtask

    task automatic model_reset();
        q_m.delete();
        infl_v  = 0;
        stall_m = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({push, q, req_stall} !== 66'd0) begin
            fails++;
            $display("FAIL reset_state got push=%b q=%h stall=%b exp all zero", push, q, req_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 128; i++) begin
            drive(0, 1, 13'(i), {$urandom, $urandom}, 0);
            tests++;
            if ({push, q, req_stall} !== expected()) begin
                fails++;
                $display("FAIL fill cyc=%0d got %h exp %h", i, {push, q, req_stall}, expected());
            end
            advance();
        end
    endtask

    task automatic test_basic();
        int hits = 0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       drive(0, 1, 13'h005, 64'h1111_2222_3333_4444, 0);
                1:       drive(1, 0, 13'h005, 64'd0, 0);
                default: drive(0, 0, 13'h000, 64'd0, 0);
            endcase
            tests++;
            if ({push, q, req_stall} !== expected()) begin
                fails++;
                $display("FAIL basic cyc=%0d got %h exp %h", i, {push, q, req_stall}, expected());
            end
            if (push && i == 3 && q === 64'h1111_2222_3333_4444) hits++;
            advance();
        end
        tests++;
        if (hits != 1) begin
            fails++;
            $display("FAIL basic_latency got %0d pushes at ld+2 exp 1", hits);
        end
    endtask

    task automatic test_collision();
        logic [63:0] seen [$];
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       drive(0, 1, 13'h010, 64'hA, 0);
                1:       drive(1, 1, 13'h010, 64'hB, 0);
                2:       drive(1, 0, 13'h010, 64'd0, 0);
                default: drive(0, 0, 13'h000, 64'd0, 0);
            endcase
            tests++;
            if ({push, q, req_stall} !== expected()) begin
                fails++;
                $display("FAIL collision cyc=%0d got %h exp %h", i, {push, q, req_stall}, expected());
            end
            if (push) seen.push_back(q);
            advance();
        end
        tests++;
        if (seen.size() != 2 || seen[0] !== 64'hA || seen[1] !== 64'hB) begin
            fails++;
            $display("FAIL collision_order got n=%0d exp 2 (A then B)", seen.size());
        end
    endtask

    task automatic test_streaming();
        int  npush = 0;
        bit  stall_seen = 0;
        logic [63:0] exp_q [$];
        for (int i = 0; i < 100; i++) exp_q.push_back(mem_m[i]);
        for (int i = 0; i < 104; i++) begin
            if (i < 100) drive(1, 0, 13'(i), 64'd0, 0);
            else         drive(0, 0, 13'd0, 64'd0, 0);
            tests++;
            if ({push, q, req_stall} !== expected()) begin
                fails++;
                $display("FAIL stream cyc=%0d got %h exp %h", i, {push, q, req_stall}, expected());
            end
            if (req_stall) stall_seen = 1;
            if (push) begin
                if (npush < 100 && (i != npush + 2 || q !== exp_q[npush])) begin
                    tests++; fails++;
                    $display("FAIL stream_seq push#%0d at cyc %0d q=%h exp cyc %0d", npush, i, q, npush + 2);
                end
                npush++;
            end
            advance();
        end
        tests++;
        if (npush != 100 || stall_seen) begin
            fails++;
            $display("FAIL stream_total got pushes=%0d stall=%b exp 100/0", npush, stall_seen);
        end
    endtask

    task automatic test_backpressure();
        bit stall_prev = 0;
        bit stall_seen = 0;
        int max_occ = 0;
        for (int i = 0; i < 36; i++) begin
            logic l;
            logic r;
            r = (i < 20);
            l = (i < 20) && !stall_prev;
            drive(l, 0, 13'($urandom_range(0, 127)), 64'd0, r);
            tests++;
            if ({push, q, req_stall} !== expected()) begin
                fails++;
                $display("FAIL backpressure cyc=%0d got %h exp %h", i, {push, q, req_stall}, expected());
            end
            stall_prev = req_stall;
            if (req_stall) stall_seen = 1;
            advance();
            if (q_m.size() + int'(infl_v) > max_occ) max_occ = q_m.size() + int'(infl_v);
        end
        tests++;
        if (!stall_seen || max_occ > DEPTH || q_m.size() != 0) begin
            fails++;
            $display("FAIL backpressure_bound got stall_seen=%b max_occ=%0d left=%0d exp 1/<=8/0",
                     stall_seen, max_occ, q_m.size());
        end
    endtask

    task automatic test_random();
        bit stall_prev = 0;
        for (int i = 0; i < 400; i++) begin
            logic l;
            l = ($urandom_range(0, 3) != 0) && !stall_prev;
            drive(l, ($urandom_range(0, 2) == 0), 13'($urandom_range(0, 127)),
                  {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
            tests++;
            if ({push, q, req_stall} !== expected()) begin
                fails++;
                $display("FAIL random cyc=%0d got %h exp %h", i, {push, q, req_stall}, expected());
            end
            stall_prev = req_stall;
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, 0, 13'(20 + i), 64'd0, 1);
            advance();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({push, req_stall, q} !== 66'd0) begin
            fails++;
            $display("FAIL reset_mid got push=%b stall=%b q=%h exp 0/0/0", push, req_stall, q);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) drive(1, 0, 13'(40 + i), 64'd0, 0);
            else       drive(0, 0, 13'd0, 64'd0, 0);
            tests++;
            if ({push, q, req_stall} !== expected()) begin
                fails++;
                $display("FAIL reset_after cyc=%0d got %h exp %h", i, {push, q, req_stall}, expected());
            end
            advance();
        end
    endtask

`ifdef SCRATCH_OVERFLOW_CHECK_EN
    task automatic test_overflow();
        for (int i = 0; i < 22; i++) begin
            drive(i < 10, 0, 13'($urandom_range(0, 127)), 64'd0, i < 12);
            tests++;
            if ({push, q, req_stall} !== expected()) begin
                fails++;
                $display("FAIL overflow cyc=%0d got %h exp %h", i, {push, q, req_stall}, expected());
            end
            if (i >= 11) begin
                tests++;
                if (err_overflow !== 1'b1) begin
                    fails++;
                    $display("FAIL err_overflow cyc=%0d got %b exp 1", i, err_overflow);
                end
            end else if (i <= 9) begin
                tests++;
                if (err_overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL err_overflow_early cyc=%0d got %b exp 0", i, err_overflow);
                end
            end
            advance();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_collision();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef SCRATCH_OVERFLOW_CHECK_EN
        test_overflow();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
